// File: rtl/stream_mux.sv
// -----------------------------------------------------------------------------
// stream_mux
//
// Selects one of CHANNELS valid/ready input streams and forwards each accepted
// word through a single registered output stage. The output stage is a
// one-word skid-free register. It reloads in the same cycle that its current
// word is accepted, so a steady stream runs at one word per clock.
//
// Arbitration is chosen at build time with the macro STREAM_MUX_RR_EN:
//   undefined (default): fixed mode. Channel `sel` is granted. A select value
//                        >= CHANNELS grants nothing.
//   defined            : round-robin mode. `sel` is ignored. The search for a
//                        valid channel starts one past the last channel that
//                        transferred.
//
// Ports
//   clk        in   1               rising-edge clock
//   rst        in   1               synchronous, active-high reset
//   in_data    in   CHANNELS*WIDTH  channel k at [k*WIDTH +: WIDTH]
//   in_valid   in   CHANNELS        per-channel valid
//   in_ready   out  CHANNELS        per-channel ready (combinational, one-hot or 0)
//   sel        in   SEL_W           channel select (fixed mode only)
//   out_data   out  WIDTH           registered output word
//   out_chan   out  SEL_W           channel that supplied out_data
//   out_valid  out  1               output register holds a word
//   out_ready  in   1               downstream accepts the word
//   xfer_cnt   out  32              completed output transfers, wraps
// -----------------------------------------------------------------------------
module stream_mux #(
    parameter  int WIDTH    = 32,
    parameter  int CHANNELS = 8,
    localparam int SEL_W    = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [CHANNELS*WIDTH-1:0] in_data,
    input  logic [CHANNELS-1:0]       in_valid,
    output logic [CHANNELS-1:0]       in_ready,
    input  logic [SEL_W-1:0]          sel,
    output logic [WIDTH-1:0]          out_data,
    output logic [SEL_W-1:0]          out_chan,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [31:0]               xfer_cnt
);

    logic                load_en;    // output register can take a new word
    logic                grant_ok;   // some channel is granted this cycle
    logic [SEL_W-1:0]    grant_idx;  // index of the granted channel
    logic [CHANNELS-1:0] grant;      // one-hot form of grant_idx
    logic                xfer;       // granted channel is valid and loads
    logic [WIDTH-1:0]    mux_data;

    assign load_en = !out_valid || out_ready;

`ifdef STREAM_MUX_RR_EN
    logic [SEL_W-1:0] rr_ptr;        // last channel that transferred
    logic             unused_sel;

    assign unused_sel = ^sel;

    // Each channel's distance from rr_ptr+1 going upward (mod CHANNELS) is
    // compared. The valid channel nearest that starting point wins.
    always_comb begin : rr_search
        int best;
        int dist;
        // NOTE: every variable written here gets a default first, so no path
        // leaves it unassigned and no latch is inferred.
        best      = CHANNELS;
        dist      = 0;
        grant_idx = '0;
        for (int k = 0; k < CHANNELS; k++) begin
            dist = (k - int'(rr_ptr) - 1 + 2 * CHANNELS) % CHANNELS;
            if (in_valid[k] && dist < best) begin
                best      = dist;
                grant_idx = SEL_W'(k);
            end
        end
        grant_ok = (best < CHANNELS);
    end
`else
    assign grant_idx = sel;

    // When CHANNELS fills the select range, every select value is legal.
    if (CHANNELS == (1 << SEL_W)) begin : g_sel_full
        assign grant_ok = 1'b1;
    end else begin : g_sel_part
        assign grant_ok = (32'(sel) < CHANNELS);
    end
`endif

    always_comb begin
        grant    = '0;
        mux_data = '0;
        for (int k = 0; k < CHANNELS; k++) begin
            grant[k] = grant_ok && (grant_idx == SEL_W'(k));
            if (grant[k]) begin
                mux_data = in_data[k*WIDTH +: WIDTH];
            end
        end
    end

    assign in_ready = rst ? '0 : (grant & {CHANNELS{load_en}});
    assign xfer     = load_en && |(grant & in_valid);

    // Reset takes priority over everything. A word that is leaving while rst
    // is high is dropped and is not counted.
    // NOTE: state registers use non-blocking assignments so that every flop
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_chan  <= '0;
            xfer_cnt  <= '0;
`ifdef STREAM_MUX_RR_EN
            rr_ptr    <= SEL_W'(CHANNELS - 1);
`endif
        end else begin
            if (out_valid && out_ready) begin
                xfer_cnt <= xfer_cnt + 32'd1;
            end
            if (xfer) begin
                out_data  <= mux_data;
                out_chan  <= grant_idx;
                out_valid <= 1'b1;
`ifdef STREAM_MUX_RR_EN
                rr_ptr    <= grant_idx;
`endif
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule
